alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_seq_if.sv | 15 +
 rtl/alu_seq_muldiv.sv | 71 +++++++
 rtl/alu_seq.sv | 87 ++++++++
 tb/tb_alu_seq.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and default width for the sequential ALU.
package alu_seq_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_OR  = 4'h1,
    OP_NOT = 4'h2,
    OP_NEG = 4'h3,
    OP_ROL = 4'h4,
    OP_ROR = 4'h5,
    OP_MUL = 4'h6,
    OP_DIV = 4'h7
  } op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between an ALU client and alu_seq.
interface alu_seq_if #(parameter int WIDTH = alu_seq_pkg::WIDTH_DEF);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] ry;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             dbz;
  logic             illegal;
  modport master (output start, op, rb, ry, input busy, done, result_lo, result_hi, dbz, illegal);
  modport slave (input start, op, rb, ry, output busy, done, result_lo, result_hi, dbz, illegal);
endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative shift-add multiply / restoring divide on magnitudes, signs applied on output.
module alu_seq_muldiv #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int LW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] p_q, p_d, prod;
  logic [WIDTH-1:0]   m_q, m_d, mag_a, mag_b;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d, neg_q, neg_d, sgn_q, sgn_d;
  logic [WIDTH:0]     add_s, sub_s, sh;
  // p holds {accumulator/remainder, multiplier/quotient}; m holds multiplicand/divisor
  always_comb begin
    mag_a = a[WIDTH-1] ? -a : a;
    mag_b = b[WIDTH-1] ? -b : b;
    sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    sub_s = sh - {1'b0, m_q};
    add_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    p_d = p_q;
    m_d = m_q;
    cnt_d = cnt_q;
    div_d = div_q;
    neg_d = neg_q;
    sgn_d = sgn_q;
    if (load) begin
      p_d = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
      m_d = is_div ? mag_b : mag_a;
      cnt_d = '0;
      div_d = is_div;
      neg_d = a[WIDTH-1] ^ b[WIDTH-1];
      sgn_d = a[WIDTH-1];
    end else if (run) begin
      p_d = div_q ? (sub_s[WIDTH] ? {sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                  : {sub_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1})
                  : {add_s, p_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      sgn_q <= 1'b0;
    end else begin
      p_q <= p_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      neg_q <= neg_d;
      sgn_q <= sgn_d;
    end
  end
  // quotient sign is the operand sign xor; remainder follows the dividend
  always_comb begin
    last = &cnt_q;
    prod = neg_q ? -p_q : p_q;
    res_lo = div_q ? (neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]) : prod[WIDTH-1:0];
    res_hi = div_q ? (sgn_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU; single-cycle logic/rotate ops, iterative signed mul/div.
module alu_seq import alu_seq_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input logic   clk,
  input logic   reset_n,
  alu_seq_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic             done_q, done_d, dbz_q, dbz_d, ill_q, ill_d, load, last;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, md_lo, md_hi, lg;
  logic [LW-1:0]    amt, amt_n;
  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk), .reset_n(reset_n), .load(load), .run(state_q == RUN),
    .is_div(bus.op == OP_DIV), .a(bus.rb), .b(bus.ry),
    .last(last), .res_lo(md_lo), .res_hi(md_hi)
  );
  // rotate by the complementary amount fills the wrapped bits; amount 0 gives rb
  always_comb begin
    amt = bus.ry[LW-1:0];
    amt_n = -amt;
    case (bus.op)
      OP_AND:  lg = bus.rb & bus.ry;
      OP_OR:   lg = bus.rb | bus.ry;
      OP_NOT:  lg = ~bus.rb;
      OP_NEG:  lg = -bus.rb;
      OP_ROL:  lg = (bus.rb << amt) | (bus.rb >> amt_n);
      OP_ROR:  lg = (bus.rb >> amt) | (bus.rb << amt_n);
      default: lg = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    dbz_d = dbz_q;
    ill_d = ill_q;
    lo_d = lo_q;
    hi_d = hi_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        dbz_d = 1'b0;
        ill_d = 1'b0;
        if (bus.op == OP_MUL || (bus.op == OP_DIV && |bus.ry)) begin
          load = 1'b1;
          state_d = RUN;
        end else begin
          done_d = 1'b1;
          lo_d = (bus.op == OP_DIV) ? '1 : lg;
          hi_d = (bus.op == OP_DIV) ? bus.rb : '0;
          dbz_d = bus.op == OP_DIV;
          ill_d = bus.op[3];
        end
      end
      RUN: state_d = last ? FIX : RUN;
      FIX: begin
        lo_d = md_lo;
        hi_d = md_hi;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      ill_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      state_q <= state_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
      ill_q <= ill_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.dbz = dbz_q;
  assign bus.illegal = ill_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, corner sequences and random ops against an arithmetic model.
module tb_alu_seq;
  import alu_seq_pkg::*;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] rb;
    logic [31:0] ry;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    logic        ill;
    int          lat;
  } vec_t;
  logic clk, reset_n;
  int checks = 0, failures = 0;
  alu_seq_if #(.WIDTH(32)) bus();
  alu_seq #(.WIDTH(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint sa, sb;
    logic [63:0] pu;
    v = '{o, a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_AND: v.lo = a & b;
      OP_OR:  v.lo = a | b;
      OP_NOT: v.lo = ~a;
      OP_NEG: begin pu = -sa; v.lo = pu[31:0]; end
      OP_ROL: begin v.lo = a; for (int i = 0; i < int'(b % 32); i++) v.lo = {v.lo[30:0], v.lo[31]}; end
      OP_ROR: begin v.lo = a; for (int i = 0; i < int'(b % 32); i++) v.lo = {v.lo[0], v.lo[31:1]}; end
      OP_MUL: begin pu = sa * sb; {v.hi, v.lo} = pu; v.lat = 34; end
      OP_DIV: if (b == 0) begin
        v.lo = '1; v.hi = a; v.dbz = 1'b1;
      end else begin
        pu = sa / sb; v.lo = pu[31:0];
        pu = sa % sb; v.hi = pu[31:0];
        v.lat = 34;
      end
      default: v.ill = 1'b1;
    endcase
    return v;
  endfunction
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.rb = a; bus.ry = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic apply(input string nm, input vec_t v);
    int lat;
    issue(v.op, v.rb, v.ry, lat);
    chk({nm, "_lat"}, 64'(lat), 64'(v.lat));
    chk({nm, "_lo"}, 64'(bus.result_lo), 64'(v.lo));
    chk({nm, "_hi"}, 64'(bus.result_hi), 64'(v.hi));
    chk({nm, "_dbz"}, 64'(bus.dbz), 64'(v.dbz));
    chk({nm, "_ill"}, 64'(bus.illegal), 64'(v.ill));
  endtask
  vec_t vecs[14];
  initial begin
    int lat, nd;
    logic [31:0] lo_s, hi_s;
    logic [3:0] o;
    logic [31:0] a, b;
    vecs[0]  = '{OP_MUL, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
    vecs[1]  = '{OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
    vecs[2]  = '{OP_DIV, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      1'b1, 1'b0, 1};
    vecs[3]  = '{OP_ROL, 32'h80000001, 32'd4,        32'h00000018, 32'h0,        1'b0, 1'b0, 1};
    vecs[4]  = '{OP_ROR, 32'h80000001, 32'd36,       32'h18000000, 32'h0,        1'b0, 1'b0, 1};
    vecs[5]  = '{OP_NEG, 32'h80000000, 32'd0,        32'h80000000, 32'h0,        1'b0, 1'b0, 1};
    vecs[6]  = '{4'hF,   32'h12345678, 32'h9,        32'h0,        32'h0,        1'b0, 1'b1, 1};
    vecs[7]  = '{OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0,        1'b0, 1'b0, 1};
    vecs[8]  = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b0, 34};
    vecs[9]  = '{OP_OR,  32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 32'h0,        1'b0, 1'b0, 1};
    vecs[10] = '{OP_NOT, 32'h0,        32'h5,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1};
    vecs[11] = '{OP_ROL, 32'h12345678, 32'h20,       32'h12345678, 32'h0,        1'b0, 1'b0, 1};
    vecs[12] = '{OP_MUL, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 1'b0, 1'b0, 34};
    vecs[13] = '{OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        1'b0, 1'b0, 34};
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.rb = '0; bus.ry = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_lo", 64'(bus.result_lo), 64'd0);
    chk("rst_hi", 64'(bus.result_hi), 64'd0);
    chk("rst_flags", 64'({bus.dbz, bus.illegal}), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), vecs[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_lo", 64'(bus.result_lo), 64'(vecs[13].lo));
    chk("hold_hi", 64'(bus.result_hi), 64'(vecs[13].hi));
    chk("hold_done", 64'(bus.done), 64'd0);
    // start pulsed mid-MUL must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.rb = 32'hFFFFFFFD; bus.ry = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    nd = 0; lat = 0; lo_s = '0; hi_s = '0;
    for (int c = 1; c <= 45; c++) begin
      if (bus.done) begin nd++; lat = c; lo_s = bus.result_lo; hi_s = bus.result_hi; end
      if (c == 5) begin
        chk("mul_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b1; bus.op = OP_AND; bus.rb = 32'hF0F0; bus.ry = 32'hFF00;
      end
      if (c == 6) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_lo", 64'(lo_s), 64'hFFFFFFEB);
    chk("ign_hi", 64'(hi_s), 64'hFFFFFFFF);
    // reset during DIV aborts, start in the reset cycle is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.rb = 32'd1000; bus.ry = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    bus.start = 1'b1; bus.op = OP_AND; bus.rb = 32'hFFFF; bus.ry = 32'hFFFF;
    @(posedge clk); #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_lo", 64'(bus.result_lo), 64'd0);
    chk("abort_hi", 64'(bus.result_hi), 64'd0);
    chk("abort_flags", 64'({bus.dbz, bus.illegal}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1; bus.start = 1'b0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) nd++;
    end
    chk("abort_quiet", 64'(nd), 64'd0);
    apply("post_rst_and", '{OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'h0, 1'b0, 1'b0, 1});
    // randomized ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 8));
      if (o == 4'd8) o = 4'($urandom_range(8, 15));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($signed(b) >>> 24);
      apply($sformatf("rnd%0d_op%0h", i, o), model(o, a, b));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
